// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants and types for the instruction-fetch stage
package if_fetch_unit_pkg;
   localparam logic [31:0] NOP          = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   typedef enum logic {IDLE, WAIT} state_t;
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;
endpackage

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: QDEPTH-entry FIFO of {inst, pc} with sync clear, push/pop, count and head
module if_fetch_queue #(
   parameter int QDEPTH = 2,
   localparam int AW = $clog2(QDEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [63:0]   din_i,
   output logic [CW-1:0] count_o,
   output logic [63:0]   head_o
);
   logic [63:0]   mem_q [QDEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [CW-1:0] cnt_q;
   logic          do_pop;
   assign do_pop  = pop_i && cnt_q != '0;
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];
   // Pointer and occupancy bookkeeping; clear wins over push and pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (do_pop) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
      end
   end
   // Entry storage; no reset needed since count gates visibility.
   always_ff @(posedge clk) begin
      if (push_i && !clr_i) mem_q[wr_q] <= din_i;
   end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, single-outstanding imem req/gnt/rvalid, instruction queue to decode, redirect flush (optional IF_MISALIGN_CHECK_EN)
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic        fetch_misalign
);
   localparam int CW = $clog2(QDEPTH) + 1;
   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d, req_pc_q, last_pc_q, tgt_pc;
   logic          epoch_q, tag_q, mis_q, mis_redir;
   logic          fire, resp, push;
   logic [CW-1:0] count;
   logic [63:0]   head;
   logic [CW:0]   inflight;
`ifdef IF_MISALIGN_CHECK_EN
   assign mis_redir      = redirect_pc[1:0] != 2'b00;
   assign tgt_pc         = redirect_pc;
   assign fetch_misalign = mis_q;
`else
   assign mis_redir      = 1'b0;
   assign tgt_pc         = redirect_pc & ~32'h3;
   assign fetch_misalign = 1'b0;
`endif
   assign inflight  = {1'b0, count} + (CW+1)'(state_q == WAIT);
   assign imem_req  = rst && !redirect && !mis_q && inflight < (CW+1)'(QDEPTH);
   assign imem_addr = fetch_pc_q;
   assign id_valid  = count != '0;
   assign id_inst   = id_valid ? head[63:32] : NOP;
   assign id_pc     = id_valid ? head[31:0] : last_pc_q;
   // Handshake decode: a response is kept only if its tag matches the live epoch and no redirect flushes it.
   always_comb begin
      fire       = imem_req && imem_gnt;
      resp       = state_q == WAIT && imem_rvalid;
      push       = resp && tag_q == epoch_q && !redirect;
      state_d    = fire ? WAIT : resp ? IDLE : state_q;
      fetch_pc_d = redirect ? tgt_pc : fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
   end
   // Fetch state; a redirect re-tags any in-flight request with the retiring epoch so even back-to-back redirects keep it stale.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         last_pc_q  <= RESET_PC;
         epoch_q    <= 1'b0;
         tag_q      <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         epoch_q    <= epoch_q ^ redirect;
         if (fire) req_pc_q <= fetch_pc_q;
         if (fire || redirect) tag_q <= epoch_q;
         if (redirect) mis_q <= mis_redir;
         if (id_valid) last_pc_q <= head[31:0];
      end
   end
   if_fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (redirect),
      .push_i  (push),
      .pop_i   (id_valid && id_ready),
      .din_i   ({imem_rdata, req_pc_q}),
      .count_o (count),
      .head_o  (head)
   );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: random + directed bench with in-order memory model and instruction-stream scoreboard
module tb_if_fetch_unit;
   import if_fetch_unit_pkg::*;
   logic        clk = 1'b0, rst = 1'b0;
   logic        imem_req, imem_gnt, imem_rvalid, redirect, id_valid, id_ready, fetch_misalign;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, id_inst, id_pc;
   typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
   typedef struct {logic [31:0] addr; int due;} pend_t;
   exp_t        exp_q[$];
   pend_t       pend_q[$];
   int          errors = 0, checks = 0, cyc = 0, pops = 0;
   int          gnt_pct = 100, lat_lo = 1, lat_hi = 1;
   logic [31:0] next_pc = '0;
   bit          stream_on = 1'b0;
   logic        prev_req = 1'b0, prev_gnt = 1'b0;
   logic [31:0] prev_addr = '0;

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
      .fetch_misalign(fetch_misalign)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'hC0DE_0001;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic refill();
      while (stream_on && exp_q.size() < 16) begin
         exp_q.push_back('{next_pc, mem_word(next_pc)});
         next_pc += 32'd4;
      end
   endtask

   // One clock of stimulus: decode/redirect inputs, then an in-order single-outstanding memory.
   task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit on_rv = 1'b0);
      @(negedge clk);
      cyc++;
      imem_rvalid = pend_q.size() != 0 && pend_q[0].due <= cyc;
      imem_rdata  = imem_rvalid ? mem_word(pend_q[0].addr) : 32'h0;
      id_ready    = rdy;
      redirect    = redir || (on_rv && imem_rvalid);
      redirect_pc = rpc;
      #1;
      imem_gnt = imem_req && (pend_q.size() == 0 || imem_rvalid) && $urandom_range(99) < gnt_pct;
      if (imem_rvalid) void'(pend_q.pop_front());
      if (imem_gnt) pend_q.push_back('{imem_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
      if (redirect) begin
         exp_q.delete();
`ifdef IF_MISALIGN_CHECK_EN
         stream_on = rpc[1:0] == 2'b00;
         next_pc   = rpc;
`else
         stream_on = 1'b1;
         next_pc   = rpc & ~32'h3;
`endif
      end
      refill();
   endtask

   // Monitor: every accepted instruction must be the next one of the expected stream; held requests must stay stable.
   always @(negedge clk) begin : mon
      exp_t e;
      #3;
      if (rst) begin
         if (prev_req && !prev_gnt && !redirect) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, prev_addr);
         end
         if (id_valid && id_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: got pc %h, expected no instruction", id_pc);
            end else begin
               e = exp_q.pop_front();
               chk("id_pc", id_pc, e.pc);
               chk("id_inst", id_inst, e.inst);
               pops++;
            end
         end
         prev_req  = imem_req;
         prev_gnt  = imem_gnt;
         prev_addr = imem_addr;
      end else prev_req = 1'b0;
   end

   initial begin
      int          n;
      logic [31:0] a, t;
      redirect = 0; redirect_pc = 0; id_ready = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_inst", id_inst, NOP);
      chk("rst_pc", id_pc, 32'h0);
      chk("rst_mis", 32'(fetch_misalign), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      next_pc = 32'h0;
      stream_on = 1'b1;
      refill();
      step(0, 0, 1);
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      repeat (20) step(0, 0, 1);
      repeat (6) step(0, 0, 0);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_valid", 32'(id_valid), 32'd1);
      repeat (10) step(0, 0, 1);
      lat_lo = 4; lat_hi = 4;
      n = 0;
      do begin step(0, 0, 1); n++; end while (!imem_gnt && n < 20);
      chk("slow_grant_seen", 32'(imem_gnt), 32'd1);
      lat_lo = 1; lat_hi = 1;
      step(1, 32'h100, 1);
      n = 0;
      do begin step(0, 0, 0); n++; end while (!id_valid && n < 20);
      chk("redir_first_pc", id_pc, 32'h100);
      repeat (8) step(0, 0, 1);
      n = 0;
      do begin step(0, 32'h200, 1, 1); n++; end while (!redirect && n < 20);
      chk("rv_redirect_seen", 32'(redirect), 32'd1);
      step(0, 0, 1);
      chk("rv_flush_valid", 32'(id_valid), 32'd0);
      chk("rv_req", 32'(imem_req), 32'd1);
      chk("rv_addr", imem_addr, 32'h200);
      repeat (6) step(0, 0, 1);
      gnt_pct = 0;
      step(0, 0, 1);
      a = imem_addr;
      repeat (3) step(0, 0, 1);
      chk("nogrant_req", 32'(imem_req), 32'd1);
      chk("nogrant_addr", imem_addr, a);
      gnt_pct = 100;
      repeat (6) step(0, 0, 1);
      step(1, 32'h102, 1);
      step(0, 0, 1);
`ifdef IF_MISALIGN_CHECK_EN
      chk("mis_set", 32'(fetch_misalign), 32'd1);
      chk("mis_req", 32'(imem_req), 32'd0);
      repeat (3) step(0, 0, 1);
      chk("mis_hold_req", 32'(imem_req), 32'd0);
      step(1, 32'h200, 1);
      step(0, 0, 1);
      chk("mis_clear", 32'(fetch_misalign), 32'd0);
      chk("mis_resume_addr", imem_addr, 32'h200);
`else
      chk("mis_off", 32'(fetch_misalign), 32'd0);
      chk("mis_off_addr", imem_addr, 32'h100);
`endif
      repeat (10) step(0, 0, 1);
      gnt_pct = 70; lat_lo = 1; lat_hi = 3;
      repeat (800) begin
         t = $urandom & 32'h0000_FFFC;
         if ($urandom_range(7) == 0) t[1:0] = 2'($urandom_range(3, 1));
         step($urandom_range(99) < 3, t, $urandom_range(99) < 70);
      end
      gnt_pct = 100; lat_lo = 1; lat_hi = 1;
      step(1, 32'h300, 1);
      repeat (40) step(0, 0, 1);
      chk("delivered_enough", 32'(pops >= 150), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
